// File: rtl/mem_stage_pkg.sv
// Memory stage shared types: execute->memory bus layout,
// load opcode bit positions and outbound bus widths.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 114;
  localparam int MS_TO_WS_BUS_WD = 73;
  localparam int MS_EX_BUS_WD    = 10;

  localparam int LD_LB  = 6;
  localparam int LD_LBU = 5;
  localparam int LD_LH  = 4;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 2;
  localparam int LD_LWL = 1;
  localparam int LD_LWR = 0;

  typedef struct packed {
    logic [6:0]  ld_op;
    logic [31:0] rt_value;
    logic        res_from_mem;
    logic        req_sent;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic       bd;
    logic       sys;
    logic       mfc0;
    logic       mtc0;
    logic       eret;
    logic [4:0] c0_addr;
  } ex_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data aligner: picks/extends the addressed bytes and
// merges unaligned lwl/lwr words with the old rt value.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [6:0]  ld_op,
  input  logic [1:0]  k,
  input  logic [31:0] d,
  input  logic [31:0] rt_value,
  output logic [31:0] result,
  output logic [3:0]  strb
);

  logic [7:0]  byte_k;
  logic [15:0] half_k;
  logic [4:0]  sh_l;
  logic [4:0]  sh_r;
  logic [31:0] mask_l;
  logic [31:0] mask_r;

  assign byte_k = d[{k, 3'b000} +: 8];
  assign half_k = d[{k[1], 4'b0000} +: 16];
  assign sh_l   = {~k, 3'b000};
  assign sh_r   = {k, 3'b000};
  assign mask_l = 32'hffff_ffff << sh_l;
  assign mask_r = 32'hffff_ffff >> sh_r;

  always_comb begin
    result = d;
    strb   = 4'hf;
    unique case (1'b1)
      ld_op[LD_LB]:  result = {{24{byte_k[7]}}, byte_k};
      ld_op[LD_LBU]: result = {24'h0, byte_k};
      ld_op[LD_LH]:  result = {{16{half_k[15]}}, half_k};
      ld_op[LD_LHU]: result = {16'h0, half_k};
      ld_op[LD_LW]:  result = d;
      ld_op[LD_LWL]: begin
        result = (d << sh_l) | (rt_value & ~mask_l);
        strb   = 4'hf << ~k;
      end
      ld_op[LD_LWR]: begin
        result = (d >> sh_r) | (rt_value & ~mask_r);
        strb   = 4'hf >> k;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: waits for data responses, aligns load data
// and drops responses owed to flushed requests.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [MS_EX_BUS_WD-1:0]    es_ex_bus,
  input  logic                       es_req_cancel,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       flush,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_EX_BUS_WD-1:0]    ms_ex_bus,
  output logic                       ms_write_reg,
  output logic [4:0]                 ms_reg_dest,
  output logic                       ms_load_pending,
  output logic                       ms_ex
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX =
    SUM_W'((1 << CNT_W) - 1);

  es_to_ms_t es_in;
  ex_t       ex_r;
  ms_to_ws_t ws_out;

  logic [6:0]  ld_op_r;
  logic [31:0] rt_r;
  logic        mem_r;
  logic [3:0]  we_r;
  logic [4:0]  dest_r;
  logic [31:0] alu_r;
  logic [31:0] pc_r;

  logic             ms_valid;
  logic             waiting;
  logic             buf_valid;
  logic [31:0]      buf_data;
  logic [CNT_W-1:0] discard_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [SUM_W-1:0] cnt_sum;

  logic        discard;
  logic        take;
  logic        lost;
  logic        ms_ready_go;
  logic [31:0] ld_data;
  logic [31:0] align_result;
  logic [3:0]  align_strb;

  assign es_in = es_to_ms_bus;

  assign discard = data_sram_data_ok & (discard_cnt != '0);
  assign take    = data_sram_data_ok & ~discard
                 & ms_valid & waiting;
  assign lost    = ms_valid & waiting & ~take;

  assign ms_ready_go    = ~waiting | take;
  assign ms_allowin     = ~ms_valid
                        | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;

  // a flushed waiter and a killed execute request each owe one response
  assign cnt_sum = SUM_W'(discard_cnt)
                 + SUM_W'(flush & lost)
                 + SUM_W'(flush & es_req_cancel)
                 - SUM_W'(discard);
  assign cnt_next = (cnt_sum > CNT_MAX)
                  ? CNT_MAX[CNT_W-1:0]
                  : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      waiting     <= 1'b0;
      buf_valid   <= 1'b0;
      discard_cnt <= '0;
    end else begin
      assert (cnt_sum < CNT_MAX);
      discard_cnt <= cnt_next;
      if (flush) begin
        ms_valid  <= 1'b0;
        waiting   <= 1'b0;
        buf_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid  <= es_to_ms_valid;
        waiting   <= es_to_ms_valid & es_in.req_sent;
        buf_valid <= 1'b0;
      end else if (take) begin
        waiting   <= 1'b0;
        buf_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      ld_op_r <= es_in.ld_op;
      rt_r    <= es_in.rt_value;
      mem_r   <= es_in.res_from_mem;
      we_r    <= es_in.gr_we;
      dest_r  <= es_in.dest;
      alu_r   <= es_in.alu_result;
      pc_r    <= es_in.pc;
      ex_r    <= es_ex_bus;
    end
    if (take) begin
      buf_data <= data_sram_rdata;
    end
  end

  assign ld_data = buf_valid ? buf_data : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .ld_op    (ld_op_r),
    .k        (alu_r[1:0]),
    .d        (ld_data),
    .rt_value (rt_r),
    .result   (align_result),
    .strb     (align_strb)
  );

  always_comb begin
    ws_out.gr_we        = 4'h0;
    ws_out.dest         = dest_r;
    ws_out.final_result = mem_r ? align_result : alu_r;
    ws_out.pc           = pc_r;
    if (ms_valid) begin
      ws_out.gr_we = mem_r ? align_strb : we_r;
    end
  end

  assign ms_to_ws_bus    = ws_out;
  assign ms_ex_bus       = ex_r;
  assign ms_write_reg    = ms_valid & (|we_r);
  assign ms_reg_dest     = dest_r;
  assign ms_load_pending = ms_valid & mem_r & ~ms_ready_go;
  assign ms_ex           = ms_valid & (ex_r.sys | ex_r.eret);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed load/flush/stall cases plus
// random traffic against a request-queue reference model.
module tb_mem_stage;

  typedef struct {
    int          op;
    logic [31:0] rt;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        mem;
    logic        req;
    logic [3:0]  we;
    logic [4:0]  dest;
    logic [9:0]  ex;
  } ins_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [113:0] es_to_ms_bus;
  logic [9:0]   es_ex_bus;
  logic         es_req_cancel;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         flush;
  logic         ms_to_ws_valid;
  logic [72:0]  ms_to_ws_bus;
  logic [9:0]   ms_ex_bus;
  logic         ms_write_reg;
  logic [4:0]   ms_reg_dest;
  logic         ms_load_pending;
  logic         ms_ex;

  always #5 clk = ~clk;

  mem_stage #(.CNT_W(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .es_ex_bus         (es_ex_bus),
    .es_req_cancel     (es_req_cancel),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .flush             (flush),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_ex_bus         (ms_ex_bus),
    .ms_write_reg      (ms_write_reg),
    .ms_reg_dest       (ms_reg_dest),
    .ms_load_pending   (ms_load_pending),
    .ms_ex             (ms_ex)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_xfer = 0;

  // stimulus for the next cycle
  logic        s_reset, s_valid, s_ws, s_flush;
  logic        s_cancel, s_dok;
  logic [31:0] s_rdata;
  ins_t        s_ins;

  // reference model: stage contents and in-order response queue
  bit          mv;
  ins_t        mi;
  bit          mrdy;
  logic [31:0] mdata;
  bit          memq[$];

  // DUT samples of the last cycle
  logic        o_valid, o_allow;
  logic [31:0] o_res;
  logic [3:0]  o_we;

  task automatic chk(input string name,
                     input logic [72:0] act,
                     input logic [72:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [113:0] pack(input ins_t x);
    logic [6:0] op;
    op = (x.op > 0) ? 7'(7'h40 >> (x.op - 1)) : 7'h0;
    return {op, x.rt, x.mem, x.req, x.we,
            x.dest, x.alu, x.pc};
  endfunction

  // byte-level view of each load flavour
  function automatic void ref_load(input int op,
                                   input logic [1:0] k,
                                   input logic [31:0] d,
                                   input logic [31:0] rt,
                                   output logic [31:0] r,
                                   output logic [3:0] w);
    logic [7:0]  db[4];
    logic [7:0]  rb[4];
    logic [7:0]  ob[4];
    logic [15:0] h;
    int kk, b0;
    kk = int'(k);
    b0 = 2 * int'(k[1]);
    for (int i = 0; i < 4; i++) begin
      db[i] = d[8*i +: 8];
      rb[i] = rt[8*i +: 8];
    end
    h = {db[b0+1], db[b0]};
    r = d;
    w = 4'hf;
    case (op)
      1: r = {{24{db[kk][7]}}, db[kk]};
      2: r = {24'h0, db[kk]};
      3: r = {{16{h[15]}}, h};
      4: r = {16'h0, h};
      6: for (int i = 0; i < 4; i++) begin
           w[i]  = (i >= 3 - kk);
           ob[i] = w[i] ? db[i-(3-kk)] : rb[i];
         end
      7: for (int i = 0; i < 4; i++) begin
           w[i]  = (i <= 3 - kk);
           ob[i] = w[i] ? db[i+kk] : rb[i];
         end
      default: ;
    endcase
    if (op == 6 || op == 7) r = {ob[3], ob[2], ob[1], ob[0]};
  endfunction

  function automatic ins_t mk(input int op,
                              input logic [31:0] alu,
                              input logic [31:0] rt);
    ins_t x;
    x.op = op; x.alu = alu; x.rt = rt;
    x.pc = 32'hbfc0_0100; x.dest = 5'd9; x.ex = 10'h0;
    x.mem = (op > 0); x.req = (op > 0);
    x.we = (op > 0) ? 4'hf : 4'h3;
    return x;
  endfunction

  function automatic ins_t rand_ins();
    ins_t x;
    int kind;
    kind = $urandom_range(0, 3);
    x.rt = $urandom; x.alu = $urandom; x.pc = $urandom;
    x.dest = 5'($urandom); x.ex = 10'($urandom);
    x.op = 0; x.mem = 0; x.req = 0;
    x.we = 4'($urandom);
    if (kind == 1) begin
      x.req = 1; x.we = 4'h0;
    end else if (kind >= 2) begin
      x.op = $urandom_range(1, 7);
      x.mem = 1; x.req = 1; x.we = 4'hf;
    end
    return x;
  endfunction

  task automatic idle();
    s_reset = 0; s_valid = 0; s_ws = 1; s_flush = 0;
    s_cancel = 0; s_dok = 0; s_rdata = 32'h0;
    s_ins = mk(0, 32'h0, 32'h0);
  endtask

  // one cycle: drive, check against model, advance model
  task automatic step();
    bit resp, mine, ready, ev, ea;
    logic [31:0] d, r;
    logic [3:0] w;
    @(negedge clk);
    reset = s_reset;
    es_to_ms_valid = s_valid;
    es_to_ms_bus = pack(s_ins);
    es_ex_bus = s_ins.ex;
    ws_allowin = s_ws;
    flush = s_flush;
    es_req_cancel = s_cancel;
    data_sram_data_ok = s_dok;
    data_sram_rdata = s_rdata;
    #1;
    resp  = s_dok && memq.size() > 0;
    mine  = resp && memq[0];
    ready = mv && (mrdy || mine);
    ev    = ready && !s_flush;
    ea    = !mv || (ready && s_ws);
    d     = mrdy ? mdata : s_rdata;
    r = mi.alu;
    w = mi.we;
    if (mi.mem) ref_load(mi.op, mi.alu[1:0], d, mi.rt, r, w);
    o_valid = ms_to_ws_valid;
    o_allow = ms_allowin;
    o_res   = ms_to_ws_bus[63:32];
    o_we    = ms_to_ws_bus[72:69];
    chk("to_ws_valid", 73'(ms_to_ws_valid), 73'(ev));
    chk("allowin", 73'(ms_allowin), 73'(ea));
    chk("load_pending", 73'(ms_load_pending),
        73'(mv && mi.mem && !ready));
    chk("write_reg", 73'(ms_write_reg),
        73'(mv && mi.we != 4'h0));
    chk("ms_ex", 73'(ms_ex),
        73'(mv && (mi.ex[8] || mi.ex[5])));
    if (ev) begin
      chk("result", 73'(o_res), 73'(r));
      chk("gr_we", 73'(o_we), 73'(w));
      chk("dest", 73'(ms_to_ws_bus[68:64]), 73'(mi.dest));
      chk("pc", 73'(ms_to_ws_bus[31:0]), 73'(mi.pc));
    end
    if (!mv) chk("idle_we", 73'(o_we), 73'(0));
    if (mv) begin
      chk("ex_bus", 73'(ms_ex_bus), 73'(mi.ex));
      chk("reg_dest", 73'(ms_reg_dest), 73'(mi.dest));
    end
    if (ev && s_ws) n_xfer++;
    if (resp) void'(memq.pop_front());
    if (s_reset) begin
      mv = 0;
      memq.delete();
    end else if (s_flush) begin
      if (mv && !mrdy && !mine)
        foreach (memq[i]) memq[i] = 0;
      if (s_cancel) memq.push_back(0);
      mv = 0;
    end else if (ea) begin
      mv = s_valid;
      if (s_valid) begin
        mi = s_ins;
        mrdy = !s_ins.req;
        if (s_ins.req) memq.push_back(1);
      end
    end else if (mine) begin
      mrdy = 1;
      mdata = s_rdata;
    end
  endtask

  task automatic rand_stim();
    int dead;
    bit mine, mark;
    s_reset = 0;
    s_valid = 1'($urandom_range(0, 1));
    s_ins = rand_ins();
    s_ws = ($urandom_range(0, 3) != 0);
    s_rdata = $urandom;
    s_dok = memq.size() > 0 && $urandom_range(0, 9) < 4;
    dead = 0;
    foreach (memq[i]) if (!memq[i]) dead++;
    if (s_dok && !memq[0]) dead--;
    mine = s_dok && memq[0];
    mark = mv && !mrdy && !mine;
    s_flush = ($urandom_range(0, 19) == 0)
           && (dead + int'(mark) <= 2);
    s_cancel = s_flush && ($urandom_range(0, 1) == 1)
            && (dead + int'(mark) + 1 <= 2);
  endtask

  task automatic do_load(input string name, input int op,
                         input logic [1:0] k,
                         input logic [31:0] rt,
                         input logic [31:0] rdata,
                         input logic [31:0] exp_r,
                         input logic [3:0] exp_w);
    idle();
    s_valid = 1;
    s_ins = mk(op, {30'h400, k}, rt);
    step();
    idle();
    s_dok = 1;
    s_rdata = rdata;
    step();
    chk({name, "_valid"}, 73'(o_valid), 73'(1));
    chk({name, "_res"}, 73'(o_res), 73'(exp_r));
    chk({name, "_we"}, 73'(o_we), 73'(exp_w));
  endtask

  initial begin
    logic [31:0] pr;
    logic [3:0]  pw;
    idle();
    reset = 1; es_to_ms_valid = 0; es_to_ms_bus = '0;
    es_ex_bus = '0; ws_allowin = 1; flush = 0;
    es_req_cancel = 0; data_sram_data_ok = 0;
    data_sram_rdata = '0;
    mv = 0; mrdy = 1; mdata = 0; mi = mk(0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_valid", 73'(ms_to_ws_valid), 73'(0));
    chk("rst_allowin", 73'(ms_allowin), 73'(1));
    chk("rst_pending", 73'(ms_load_pending), 73'(0));
    chk("rst_ex", 73'(ms_ex), 73'(0));

    ref_load(6, 2'd1, 32'hAABBCCDD, 32'h11223344, pr, pw);
    chk("model_lwl", 73'({pw, pr}), 73'({4'b1100, 32'hCCDD3344}));
    ref_load(3, 2'd2, 32'h80FF0000, 32'h0, pr, pw);
    chk("model_lh", 73'(pr), 73'(32'hFFFF80FF));

    // lw with a three-cycle response
    idle(); s_valid = 1; s_ins = mk(5, 32'h0000_1004, 0);
    step();
    idle(); step();
    chk("lw_wait", 73'(o_valid), 73'(0));
    step();
    s_dok = 1; s_rdata = 32'hDEADBEEF;
    step();
    chk("lw_valid", 73'(o_valid), 73'(1));
    chk("lw_res", 73'(o_res), 73'(32'hDEADBEEF));
    chk("lw_we", 73'(o_we), 73'(4'hf));

    do_load("lb", 1, 2'd3, 0, 32'h80FF0000, 32'hFFFFFF80, 4'hf);
    do_load("lbu", 2, 2'd2, 0, 32'h80FF0000, 32'h000000FF, 4'hf);
    do_load("lh", 3, 2'd2, 0, 32'h80FF0000, 32'hFFFF80FF, 4'hf);
    do_load("lwl", 6, 2'd1, 32'h11223344, 32'hAABBCCDD,
            32'hCCDD3344, 4'b1100);
    do_load("lwr", 7, 2'd1, 32'h11223344, 32'hAABBCCDD,
            32'h11AABBCC, 4'b0111);

    // writeback stall while the response arrives
    idle(); s_valid = 1; s_ins = mk(5, 32'h2000, 0);
    step();
    n_xfer = 0;
    idle(); s_ws = 0; s_dok = 1; s_rdata = 32'h12345678;
    step();
    chk("stall_allow0", 73'(o_allow), 73'(0));
    idle(); s_ws = 0;
    step();
    chk("stall_allow1", 73'(o_allow), 73'(0));
    idle();
    step();
    chk("stall_valid", 73'(o_valid), 73'(1));
    chk("stall_res", 73'(o_res), 73'(32'h12345678));
    chk("stall_xfer", 73'(n_xfer), 73'(1));

    // flush with a killed execute request, then refill
    idle(); s_valid = 1; s_ins = mk(5, 32'h3000, 0);
    step();
    idle(); s_flush = 1; s_cancel = 1;
    step();
    @(posedge clk); #1;
    chk("discard_cnt", 73'(dut.discard_cnt), 73'(2));
    idle(); s_valid = 1; s_ins = mk(5, 32'h3004, 0);
    step();
    idle(); s_dok = 1; s_rdata = 32'h1111_1111;
    step();
    chk("drop0", 73'(o_valid), 73'(0));
    s_rdata = 32'h2222_2222;
    step();
    chk("drop1", 73'(o_valid), 73'(0));
    s_rdata = 32'hCAFEF00D;
    step();
    chk("refill_valid", 73'(o_valid), 73'(1));
    chk("refill_res", 73'(o_res), 73'(32'hCAFEF00D));

    // reset while waiting, stale response afterwards
    idle(); s_valid = 1; s_ins = mk(5, 32'h4000, 0);
    step();
    idle(); s_reset = 1;
    step();
    idle(); s_dok = 1; s_rdata = 32'h5555_5555;
    step();
    chk("rst_stale_valid", 73'(o_valid), 73'(0));
    chk("rst_allow", 73'(o_allow), 73'(1));

    for (int c = 0; c < 4000; c++) begin
      rand_stim();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
